vec_player_capture: RTL and testbench

VEC_PLAYER_CAPTURE -- requirements
Module: vec_player_capture

---
 rtl/vec_player_capture.sv | 154 +++++++++++++++
 tb/tb_vec_player_capture.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_player_capture.sv
// Vector player / response capture: plays stored stimulus words into a DUT, compares each
// settled response against a stored expectation and folds every response into a signature.
module vec_player_capture #(
   parameter  int IN_W   = 41,
   parameter  int OUT_W  = 32,
   parameter  int DEPTH  = 16,
   parameter  int SETTLE = 1,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_en,
   input  logic [AW-1:0]     ld_addr,
   input  logic [IN_W-1:0]   ld_data,
   input  logic [OUT_W-1:0]  ld_exp,
   input  logic              start,
   input  logic              stop,
   input  logic [1:0]        mode,
   input  logic [AW:0]       num_vec,
   output logic [IN_W-1:0]   dut_in,
   input  logic [OUT_W-1:0]  dut_out,
   output logic              busy,
   output logic              done,
   output logic [AW-1:0]     vec_idx,
   output logic [15:0]       mismatch_cnt,
   output logic              fail_seen,
   output logic [AW-1:0]     first_fail_idx,
   output logic [OUT_W-1:0]  signature
);

   localparam logic [3:0]  SETTLE_LD = 4'(SETTLE - 1);
   localparam logic [AW:0] DEPTH_V   = (AW + 1)'(DEPTH);
   localparam logic [1:0]  MODE_LOOP = 2'b01;
   localparam logic [1:0]  MODE_SOM  = 2'b10;

   typedef enum logic [1:0] {IDLE, SETTLE_W, SAMPLE, DONE} state_t;

   state_t            state, state_nxt;
   logic [IN_W-1:0]   vmem [DEPTH];
   logic [OUT_W-1:0]  emem [DEPTH];
   logic [1:0]        mode_r;
   logic [AW:0]       n_r;
   logic [3:0]        settle_cnt;
   logic              mis;
   logic              last;
   logic              do_start;
   logic              do_sample;
   logic              do_advance;
   logic [AW-1:0]     idx_nxt;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [OUT_W-1:0] sig_fold(input logic [OUT_W-1:0] s,
                                                 input logic [OUT_W-1:0] r);
      return {s[OUT_W-2:0], s[OUT_W-1]} ^ r;
   endfunction

   // Memory is deliberately outside the reset domain so loaded vectors survive rst_n.
   always_ff @(posedge clk) begin
      if (ld_en && state == IDLE) begin
         vmem[ld_addr] <= ld_data;
         emem[ld_addr] <= ld_exp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      do_start   = 1'b0;
      do_sample  = 1'b0;
      do_advance = 1'b0;
      mis        = (dut_out != emem[vec_idx]);
      last       = ({1'b0, vec_idx} == n_r - 1'b1);
      idx_nxt    = (last && mode_r == MODE_LOOP) ? '0 : vec_idx + 1'b1;
      case (state)
         IDLE: begin
            if (start) begin
               do_start  = 1'b1;
               state_nxt = SETTLE_W;
            end
         end
         SETTLE_W: begin
            if (stop)                   state_nxt = DONE;
            else if (settle_cnt == 4'd0) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            do_sample = 1'b1;
            // Only loop mode runs past the last vector; stop-on-mismatch ends a clean pass too.
            if (stop)                           state_nxt = DONE;
            else if (mode_r == MODE_SOM && mis) state_nxt = DONE;
            else if (last && mode_r != MODE_LOOP) state_nxt = DONE;
            else begin
               do_advance = 1'b1;
               state_nxt  = SETTLE_W;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dut_in         <= '0;
         vec_idx        <= '0;
         mismatch_cnt   <= '0;
         fail_seen      <= 1'b0;
         first_fail_idx <= '0;
         signature      <= '0;
         mode_r         <= '0;
         n_r            <= '0;
         settle_cnt     <= '0;
      end else begin
         if (do_start) begin
            mode_r         <= (mode == 2'b11) ? 2'b00 : mode;
            n_r            <= (num_vec == '0 || num_vec > DEPTH_V) ? DEPTH_V : num_vec;
            vec_idx        <= '0;
            dut_in         <= vmem[0];
            mismatch_cnt   <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
            signature      <= '0;
            settle_cnt     <= SETTLE_LD;
         end
         if (state == SETTLE_W && settle_cnt != 4'd0)
            settle_cnt <= settle_cnt - 4'd1;
         if (do_sample) begin
            signature <= sig_fold(signature, dut_out);
            if (mis) begin
               mismatch_cnt <= sat_inc16(mismatch_cnt);
               if (!fail_seen) begin
                  fail_seen      <= 1'b1;
                  first_fail_idx <= vec_idx;
               end
            end
         end
         if (do_advance) begin
            vec_idx    <= idx_nxt;
            dut_in     <= vmem[idx_nxt];
            settle_cnt <= SETTLE_LD;
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_vec_player_capture.sv
// Table-driven bench for vec_player_capture with a behavioural DUT model and a run scoreboard.
module tb_vec_player_capture;

   localparam int IN_W   = 41;
   localparam int OUT_W  = 32;
   localparam int DEPTH  = 16;
   localparam int SETTLE = 1;
   localparam int AW     = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ld_en;
   logic [AW-1:0]     ld_addr;
   logic [IN_W-1:0]   ld_data;
   logic [OUT_W-1:0]  ld_exp;
   logic              start;
   logic              stop;
   logic [1:0]        mode;
   logic [AW:0]       num_vec;
   logic [IN_W-1:0]   dut_in;
   logic [OUT_W-1:0]  dut_out;
   logic              busy;
   logic              done;
   logic [AW-1:0]     vec_idx;
   logic [15:0]       mismatch_cnt;
   logic              fail_seen;
   logic [AW-1:0]     first_fail_idx;
   logic [OUT_W-1:0]  signature;

   int errors = 0;
   int checks = 0;

   logic [IN_W-1:0]   vec_in [DEPTH];
   logic [DEPTH-1:0]  corrupt;

   typedef struct {
      logic [1:0]       mode;
      logic [AW:0]      nv;
      logic [DEPTH-1:0] bad;
      int               stop_edge;
      bit               poke;
      bit               stop_at_start;
      logic [15:0]      e_cnt;
      logic             e_fail;
      logic [AW-1:0]    e_ffi;
      logic [AW-1:0]    e_idx;
      int               e_cyc;
   } rec_t;

   typedef struct {
      logic [15:0]      cnt;
      logic             fail;
      logic [AW-1:0]    ffi;
      logic [AW-1:0]    idx;
      int               cyc;
      logic [OUT_W-1:0] sig;
   } exp_t;

   exp_t sb_q[$];
   int   idx_q[$];
   rec_t tbl[12];

   vec_player_capture #(
      .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE(SETTLE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_exp(ld_exp), .start(start), .stop(stop), .mode(mode), .num_vec(num_vec),
      .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .vec_idx(vec_idx),
      .mismatch_cnt(mismatch_cnt), .fail_seen(fail_seen), .first_fail_idx(first_fail_idx),
      .signature(signature)
   );

   always #5 clk = ~clk;

   function automatic logic [OUT_W-1:0] f(input logic [IN_W-1:0] x);
      return x[OUT_W-1:0] ^ {x[IN_W-1:OUT_W], x[IN_W-1:OUT_W], x[IN_W-1:OUT_W], x[IN_W-1:IN_W-5]};
   endfunction

   // Modelled DUT: a fixed transform of the stimulus, with bit 0 flipped on corrupted vectors.
   always_comb begin
      dut_out = f(dut_in);
      for (int i = 0; i < DEPTH; i++)
         if (corrupt[i] && dut_in == vec_in[i]) dut_out = dut_out ^ 32'h0000_0001;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_run(input rec_t r, output logic [OUT_W-1:0] sig);
      int n;
      int k;
      int idx;
      int sample_end;
      n   = (r.nv == 0 || r.nv > DEPTH) ? DEPTH : int'(r.nv);
      k   = 0;
      idx = 0;
      sig = '0;
      idx_q.delete();
      while (k < 1000) begin
         sample_end = (SETTLE + 1) * (k + 1);
         if (r.stop_edge != 0 && r.stop_edge < sample_end) break;
         idx_q.push_back(idx);
         sig = {sig[OUT_W-2:0], sig[OUT_W-1]} ^ (f(vec_in[idx]) ^ {31'd0, r.bad[idx]});
         if (r.stop_edge == sample_end) break;
         if (r.mode == 2'b10 && r.bad[idx]) break;
         if (idx == n - 1 && r.mode != 2'b01) break;
         idx = (idx + 1) % n;
         k++;
      end
   endtask

   task automatic run_rec(input rec_t r);
      exp_t e;
      int   cyc;
      corrupt = r.bad;
      mode    = r.mode;
      num_vec = r.nv;
      model_run(r, e.sig);
      e.cnt = r.e_cnt; e.fail = r.e_fail; e.ffi = r.e_ffi; e.idx = r.e_idx; e.cyc = r.e_cyc;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b1;
      stop  = r.stop_at_start;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      cyc   = 1;
      while (!done && cyc < 2000) begin
         stop = (r.stop_edge == cyc);
         if (r.poke && cyc == 10) begin
            start = 1'b1; ld_en = 1'b1; ld_addr = AW'(5); ld_data = '1; ld_exp = '0;
         end
         @(posedge clk);
         @(negedge clk);
         stop = 1'b0; start = 1'b0; ld_en = 1'b0;
         if (idx_q.size() != 0 && cyc % (SETTLE + 1) == SETTLE)
            chk("vec_idx_seq", 64'(vec_idx), 64'(idx_q.pop_front()));
         cyc++;
      end
      chk("done_seen", 64'(done), 64'd1);
      e = sb_q.pop_front();
      chk("run_cycles", 64'(cyc), 64'(e.cyc));
      chk("mismatch_cnt", 64'(mismatch_cnt), 64'(e.cnt));
      chk("fail_seen", 64'(fail_seen), 64'(e.fail));
      chk("first_fail_idx", 64'(first_fail_idx), 64'(e.ffi));
      chk("vec_idx_end", 64'(vec_idx), 64'(e.idx));
      chk("signature", 64'(signature), 64'(e.sig));
      chk("samples_left", 64'(idx_q.size()), 64'd0);
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("busy_after_done", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      chk("hold_signature", 64'(signature), 64'(e.sig));
      chk("hold_vec_idx", 64'(vec_idx), 64'(e.idx));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_dut_in"}, 64'(dut_in), 64'd0);
      chk({tag, "_vec_idx"}, 64'(vec_idx), 64'd0);
      chk({tag, "_mcnt"}, 64'(mismatch_cnt), 64'd0);
      chk({tag, "_fail"}, 64'(fail_seen), 64'd0);
      chk({tag, "_ffi"}, 64'(first_fail_idx), 64'd0);
      chk({tag, "_sig"}, 64'(signature), 64'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit got_done;
      int n;
      rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_exp = '0;
      start = 1'b0; stop = 1'b0; mode = '0; num_vec = '0; corrupt = '0;
      for (int i = 0; i < DEPTH; i++) vec_in[i] = {9'(i + 1), 32'($urandom())};

      @(negedge clk);
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         ld_en = 1'b1; ld_addr = AW'(i); ld_data = vec_in[i]; ld_exp = f(vec_in[i]);
      end
      @(negedge clk);
      ld_en = 1'b0;

      //        mode   nv     bad       stop poke sas  cnt    fail ffi   idx    cyc
      tbl[0]  = '{2'b00, 5'd16, 16'h0000, 0,  0,   0,  16'd0, 1'b0, 4'd0, 4'd15, 33};
      tbl[1]  = '{2'b00, 5'd16, 16'h0208, 0,  0,   0,  16'd2, 1'b1, 4'd3, 4'd15, 33};
      tbl[2]  = '{2'b10, 5'd16, 16'h0208, 0,  0,   0,  16'd1, 1'b1, 4'd3, 4'd3,  9};
      tbl[3]  = '{2'b01, 5'd4,  16'h0000, 22, 0,   0,  16'd0, 1'b0, 4'd0, 4'd2,  23};
      tbl[4]  = '{2'b00, 5'd0,  16'h0000, 0,  0,   0,  16'd0, 1'b0, 4'd0, 4'd15, 33};
      tbl[5]  = '{2'b00, 5'd17, 16'h0000, 0,  0,   0,  16'd0, 1'b0, 4'd0, 4'd15, 33};
      tbl[6]  = '{2'b11, 5'd5,  16'h0008, 0,  0,   0,  16'd1, 1'b1, 4'd3, 4'd4,  11};
      tbl[7]  = '{2'b01, 5'd4,  16'h0002, 12, 0,   0,  16'd2, 1'b1, 4'd1, 4'd1,  13};
      tbl[8]  = '{2'b00, 5'd16, 16'h0000, 0,  1,   0,  16'd0, 1'b0, 4'd0, 4'd15, 33};
      tbl[9]  = '{2'b00, 5'd16, 16'h0000, 0,  0,   0,  16'd0, 1'b0, 4'd0, 4'd15, 33};
      tbl[10] = '{2'b00, 5'd8,  16'h0000, 5,  0,   0,  16'd0, 1'b0, 4'd0, 4'd2,  6};
      tbl[11] = '{2'b00, 5'd4,  16'h0000, 0,  0,   1,  16'd0, 1'b0, 4'd0, 4'd3,  9};

      for (int r = 0; r < 12; r++) run_rec(tbl[r]);

      // Reset while the player waits on vector 5, then replay from retained memory.
      corrupt = 16'h0208; mode = 2'b00; num_vec = 5'd16;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midrun_reset");
      @(negedge clk);
      rst_n = 1'b1;
      got_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) got_done = 1'b1;
      end
      chk("no_done_after_reset", 64'(got_done), 64'd0);
      run_rec(tbl[1]);

      // Counter saturation in loop mode.
      corrupt = '1; mode = 2'b01; num_vec = 5'd1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      force dut.mismatch_cnt = 16'hFFF0;
      @(negedge clk);
      release dut.mismatch_cnt;
      repeat (60) @(negedge clk);
      chk("sat_reached", 64'(mismatch_cnt), 64'hFFFF);
      repeat (20) @(negedge clk);
      chk("sat_held", 64'(mismatch_cnt), 64'hFFFF);
      stop = 1'b1;
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      stop = 1'b0;
      chk("sat_done", 64'(done), 64'd1);
      chk("sat_fail_seen", 64'(fail_seen), 64'd1);
      @(negedge clk);
      chk("sat_idle_cnt", 64'(mismatch_cnt), 64'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
